pe_array_data_out_collector: RTL and testbench
==============================================

Name: pe_array_data_out_collector

Overview:
- Drains per-column accumulator results from the PE array and buffers them in per-column FIFOs.
- Requantizes each result to the compressed activation format and writes one row-aligned word per column either to the dummy ctrl sink or to the ActBuffBanks.
- Supports a column-to-bank rotation for the ActBuffBank path.
- Sits at the PE array output, mirroring the data-in path that feeds the array.

Parameters:
- num_pe_col, 16, number of PE columns and ActBuffBanks.
- acc_width, 32, signed accumulator width per PE column output.
- activation_width, 16, signed requantized activation width.
- compressed_act_width, activation_width+1, output word: {zero_flag, act}.
- fifo_depth, 4, entries per column FIFO (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- pe_out_valid  in  [num_pe_col]  per-column result valid.
- pe_out_data  in  [num_pe_col][acc_width]  per-column signed accumulator.
- pe_out_ready  out  [num_pe_col]  per-column FIFO not full.
- start  in  1  begin a drain job; sampled only in IDLE.
- cfg_num_words  in  16  row-words to emit per job; latched at start.
- cfg_shift  in  5  arithmetic right shift amount; latched at start.
- cfg_relu  in  1  clamp negatives to 0; latched at start; see Optional Feature.
- out_sel  in  1  0 = dummy ctrl sink, 1 = ActBuffBanks; latched at start.
- cfg_bank_offset  in  2  bank rotation; latched at start.
- data_out_to_dummy_ctrl  out  [num_pe_col][compressed_act_width]  sink data.
- dummy_ctrl_valid  out  1  sink valid.
- dummy_ctrl_ready  in  1  sink ready.
- data_out_to_actbuff  out  [num_pe_col][compressed_act_width]  per-bank write data.
- actbuff_wr_valid  out  1  bank write valid (all banks).
- actbuff_wr_ready  in  1  AND of all bank ready signals.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset: all FIFOs empty; state IDLE; all outputs 0. pe_out_ready is 0 during reset and 1 after it.
- Column FIFOs:
  - Write when pe_out_valid[c] && pe_out_ready[c], in any state.
  - pe_out_ready[c] = !full[c].
  - Simultaneous push and pop on a full FIFO is not allowed: ready stays low while full.
- FSM:
  - IDLE -> RUN on start. Latch cfg_* and out_sel; clear word_cnt.
  - RUN:
    - pop_all = all FIFOs non-empty && (!ov || sel_ready), where ov is the output valid register and sel_ready is the ready signal of the selected destination.
    - On pop_all: pop every FIFO, load the output register, set ov, word_cnt++.
    - On the selected handshake (ov && sel_ready) with no pop that cycle, clear ov.
  - RUN -> DONE when the word_cnt == cfg_num_words handshake completes and ov has cleared.
  - DONE -> IDLE after one cycle; done=1 for exactly that cycle.
  - cfg_num_words=0: RUN -> DONE on the next cycle; no output is issued.
  - start in RUN or DONE is ignored.
- Latency: pe_out_valid on all columns at cycle N (FIFOs empty, sink ready) -> output valid at N+2. Throughput is 1 word/cycle.
- Requant per column:
  - s = acc >>> cfg_shift.
  - Saturate s to [-2^(activation_width-1), 2^(activation_width-1)-1].
  - zero_flag = (result == 0).
- Routing:
  - out_sel=0: column c -> data_out_to_dummy_ctrl[c]; dummy_ctrl_valid=ov; actbuff_wr_valid=0.
  - out_sel=1: column c -> data_out_to_actbuff[(c + cfg_bank_offset) mod num_pe_col]; actbuff_wr_valid=ov; dummy_ctrl_valid=0.
- Held data: data is stable while valid && !ready. Data registers of the unselected destination hold their previous values.
- Reset mid-job: immediate return to IDLE; FIFOs flushed; no done pulse.

Optional Feature:
- Macro: PE_DATA_OUT_RELU_EN.
- Defined: when latched cfg_relu=1, any saturated negative result becomes 0 with zero_flag=1.
- Undefined: cfg_relu is ignored and no ReLU logic is synthesized.

Test Plan:
1. Reset release -> all outputs 0, pe_out_ready all 1. Then start, cfg_num_words=0 -> done pulse 2 cycles after start, no valid asserted.
2. out_sel=0, shift=4, sink ready. Column c gets acc=16*(c+1) at cycle N, num_words=1 -> dummy data[c]={0, c+1} at N+2, then done.
3. Saturation: shift=0, acc=0x0001_0000 -> 0x7FFF; acc=0xFFFF_0000 -> 0x8000; acc=0 -> {1, 0x0000}.
4. out_sel=1, cfg_bank_offset=2, num_pe_col=16: column 15 data lands on bank 1 and column 0 on bank 2. actbuff_wr_ready low 5 cycles -> data held, FIFOs fill to 4, pe_out_ready drops, no data lost over 8 words.
5. Column 7 valid withheld 3 cycles while others are valid -> no pop until column 7 arrives; words stay row-aligned.
6. With PE_DATA_OUT_RELU_EN, cfg_relu=1, acc=-32 -> {1, 0}; without the macro -> signed -32>>>shift. A separate run asserts rst_n=0 mid-job -> IDLE, FIFOs empty, no done.

Source files
------------

// File: rtl/pe_array_data_out_collector.sv
// PE array output collector: per-column result FIFOs, requantization, dummy-sink / ActBuffBank routing.
// Define PE_DATA_OUT_RELU_EN to build the cfg_relu negative clamp; otherwise cfg_relu is ignored.

// Per-column result FIFO; pointer wrap relies on DEPTH being a power of two.
module pe_out_col_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dat   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// Purpose: drain PE column results row-aligned, requantize, write to dummy sink or rotated ActBuffBanks.
// Latency: all columns valid at cycle N -> output valid at N+2; sustains one word per cycle.
// Backpressure: a held output word stalls the pop; a full column FIFO drops o_pe_out_ready.
module pe_array_data_out_collector #(
  parameter int NUM_PE_COL           = 16,
  parameter int ACC_WIDTH            = 32,
  parameter int ACTIVATION_WIDTH     = 16,
  parameter int COMPRESSED_ACT_WIDTH = ACTIVATION_WIDTH + 1,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic [NUM_PE_COL-1:0]                               i_pe_out_valid,
  input  logic [NUM_PE_COL-1:0][ACC_WIDTH-1:0]                i_pe_out_data,
  output logic [NUM_PE_COL-1:0]                               o_pe_out_ready,
  input  logic                                                i_start,
  input  logic [15:0]                                         i_cfg_num_words,
  input  logic [4:0]                                          i_cfg_shift,
  input  logic                                                i_cfg_relu,
  input  logic                                                i_out_sel,
  input  logic [1:0]                                          i_cfg_bank_offset,
  output logic [NUM_PE_COL-1:0][COMPRESSED_ACT_WIDTH-1:0]     o_data_out_to_dummy_ctrl,
  output logic                                                o_dummy_ctrl_valid,
  input  logic                                                i_dummy_ctrl_ready,
  output logic [NUM_PE_COL-1:0][COMPRESSED_ACT_WIDTH-1:0]     o_data_out_to_actbuff,
  output logic                                                o_actbuff_wr_valid,
  input  logic                                                i_actbuff_wr_ready,
  output logic                                                o_busy,
  output logic                                                o_done
);
  localparam int CW = $clog2(NUM_PE_COL);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (ACTIVATION_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [15:0] r_word_cnt;
  logic [15:0] r_num_words;
  logic [4:0]  r_shift;
  logic        r_out_sel;
  logic [1:0]  r_bank_offset;
  logic        r_ov;
  logic        r_rdy_en;
  logic [NUM_PE_COL-1:0][COMPRESSED_ACT_WIDTH-1:0] r_dummy_dat;
  logic [NUM_PE_COL-1:0][COMPRESSED_ACT_WIDTH-1:0] r_actbuff_dat;

  logic [NUM_PE_COL-1:0][ACC_WIDTH-1:0]            w_fifo_dat;
  logic [NUM_PE_COL-1:0]                           w_full;
  logic [NUM_PE_COL-1:0]                           w_empty;
  logic [NUM_PE_COL-1:0][COMPRESSED_ACT_WIDTH-1:0] w_word;
  logic [NUM_PE_COL-1:0][COMPRESSED_ACT_WIDTH-1:0] w_rot;
  logic                                            w_sel_rdy;
  logic                                            w_pop_all;

`ifdef PE_DATA_OUT_RELU_EN
  logic r_relu;
`else
  logic w_unused_relu;
  assign w_unused_relu = i_cfg_relu;
`endif

  for (genvar c = 0; c < NUM_PE_COL; c++) begin : g_col
    pe_out_col_fifo #(
      .WIDTH (ACC_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (i_pe_out_valid[c] && o_pe_out_ready[c]),
      .i_dat   (i_pe_out_data[c]),
      .i_pop   (w_pop_all),
      .o_dat   (w_fifo_dat[c]),
      .o_full  (w_full[c]),
      .o_empty (w_empty[c])
    );
  end

  // Ready is held low until the first clock after reset release.
  assign o_pe_out_ready = r_rdy_en ? ~w_full : '0;

  assign w_sel_rdy = r_out_sel ? i_actbuff_wr_ready : i_dummy_ctrl_ready;
  assign w_pop_all = (r_state == S_RUN) && !(|w_empty) && (!r_ov || w_sel_rdy) &&
                     (r_word_cnt != r_num_words);

  function automatic logic [ACTIVATION_WIDTH-1:0] saturate(input logic [ACC_WIDTH-1:0] acc,
                                                           input logic [4:0]           sh);
    logic signed [ACC_WIDTH-1:0] s;
    s = $signed(acc) >>> sh;
    if (s > SAT_MAX) begin
      saturate = SAT_MAX[ACTIVATION_WIDTH-1:0];
    end else if (s < SAT_MIN) begin
      saturate = SAT_MIN[ACTIVATION_WIDTH-1:0];
    end else begin
      saturate = s[ACTIVATION_WIDTH-1:0];
    end
  endfunction

  always_comb begin
    logic [ACTIVATION_WIDTH-1:0] v_act;
    w_word = '0;
    for (int c = 0; c < NUM_PE_COL; c++) begin
      v_act = saturate(w_fifo_dat[c], r_shift);
`ifdef PE_DATA_OUT_RELU_EN
      if (r_relu && v_act[ACTIVATION_WIDTH-1]) begin
        v_act = '0;
      end
`endif
      w_word[c] = {(v_act == '0), v_act};
    end
  end

  // Bank b receives column (b - offset) mod NUM_PE_COL.
  always_comb begin
    logic [CW-1:0] v_idx;
    w_rot = '0;
    for (int b = 0; b < NUM_PE_COL; b++) begin
      v_idx    = CW'((b + NUM_PE_COL - int'(r_bank_offset)) % NUM_PE_COL);
      w_rot[b] = w_word[v_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_RUN;
      S_RUN:  if ((r_word_cnt == r_num_words) && !r_ov) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en      <= 1'b0;
      r_word_cnt    <= '0;
      r_num_words   <= '0;
      r_shift       <= '0;
      r_out_sel     <= 1'b0;
      r_bank_offset <= '0;
      r_ov          <= 1'b0;
      r_dummy_dat   <= '0;
      r_actbuff_dat <= '0;
`ifdef PE_DATA_OUT_RELU_EN
      r_relu        <= 1'b0;
`endif
    end else begin
      r_rdy_en <= 1'b1;
      if ((r_state == S_IDLE) && i_start) begin
        r_word_cnt    <= '0;
        r_num_words   <= i_cfg_num_words;
        r_shift       <= i_cfg_shift;
        r_out_sel     <= i_out_sel;
        r_bank_offset <= i_cfg_bank_offset;
`ifdef PE_DATA_OUT_RELU_EN
        r_relu        <= i_cfg_relu;
`endif
      end
      if (w_pop_all) begin
        r_ov       <= 1'b1;
        r_word_cnt <= r_word_cnt + 16'd1;
        if (r_out_sel) begin
          r_actbuff_dat <= w_rot;
        end else begin
          r_dummy_dat <= w_word;
        end
      end else if (r_ov && w_sel_rdy) begin
        r_ov <= 1'b0;
      end
    end
  end

  assign o_data_out_to_dummy_ctrl = r_dummy_dat;
  assign o_data_out_to_actbuff    = r_actbuff_dat;
  assign o_dummy_ctrl_valid       = r_ov && !r_out_sel;
  assign o_actbuff_wr_valid       = r_ov && r_out_sel;
  assign o_busy                   = (r_state != S_IDLE);
  assign o_done                   = (r_state == S_DONE);
endmodule

// File: tb/tb_pe_array_data_out_collector.sv
// Directed bench for pe_array_data_out_collector: vector table plus multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_pe_array_data_out_collector;
  localparam int NCOL = 16;
  localparam int AW   = 32;
  localparam int CW   = 17;
  localparam int BW   = NCOL * CW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                           rst_n;
  logic [NCOL-1:0]                i_pe_out_valid;
  logic [NCOL-1:0][AW-1:0]        i_pe_out_data;
  logic [NCOL-1:0]                o_pe_out_ready;
  logic                           i_start;
  logic [15:0]                    i_cfg_num_words;
  logic [4:0]                     i_cfg_shift;
  logic                           i_cfg_relu;
  logic                           i_out_sel;
  logic [1:0]                     i_cfg_bank_offset;
  logic [NCOL-1:0][CW-1:0]        o_data_out_to_dummy_ctrl;
  logic                           o_dummy_ctrl_valid;
  logic                           i_dummy_ctrl_ready;
  logic [NCOL-1:0][CW-1:0]        o_data_out_to_actbuff;
  logic                           o_actbuff_wr_valid;
  logic                           i_actbuff_wr_ready;
  logic                           o_busy;
  logic                           o_done;

  pe_array_data_out_collector dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .i_pe_out_valid           (i_pe_out_valid),
    .i_pe_out_data            (i_pe_out_data),
    .o_pe_out_ready           (o_pe_out_ready),
    .i_start                  (i_start),
    .i_cfg_num_words          (i_cfg_num_words),
    .i_cfg_shift              (i_cfg_shift),
    .i_cfg_relu               (i_cfg_relu),
    .i_out_sel                (i_out_sel),
    .i_cfg_bank_offset        (i_cfg_bank_offset),
    .o_data_out_to_dummy_ctrl (o_data_out_to_dummy_ctrl),
    .o_dummy_ctrl_valid       (o_dummy_ctrl_valid),
    .i_dummy_ctrl_ready       (i_dummy_ctrl_ready),
    .o_data_out_to_actbuff    (o_data_out_to_actbuff),
    .o_actbuff_wr_valid       (o_actbuff_wr_valid),
    .i_actbuff_wr_ready       (i_actbuff_wr_ready),
    .o_busy                   (o_busy),
    .o_done                   (o_done)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  always @(negedge clk) if (o_done) done_cnt++;

  typedef struct {
    logic [31:0] acc0;
    logic [31:0] acc_step;
    logic [4:0]  shift;
    logic        sel;
    logic [1:0]  off;
    logic [16:0] exp0;
    logic [16:0] exp_step;
  } vec_t;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < max && !seen; k++) begin
      if (o_done) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic start_job(input logic [15:0] nw, input logic [4:0] sh, input logic relu,
                           input logic sel, input logic [1:0] off);
    i_cfg_num_words   = nw;
    i_cfg_shift       = sh;
    i_cfg_relu        = relu;
    i_out_sel         = sel;
    i_cfg_bank_offset = off;
    i_start           = 1'b1;
    tick();
    i_start           = 1'b0;
  endtask

  task automatic produce_bp(output bit ok, output bit saw_full);
    int kc[NCOL];
    bit all_done;
    logic [NCOL-1:0] acc_m;
    ok = 1'b0;
    saw_full = 1'b0;
    for (int c = 0; c < NCOL; c++) kc[c] = 0;
    for (int t = 0; t < 200; t++) begin
      all_done = 1'b1;
      for (int c = 0; c < NCOL; c++) begin
        if (kc[c] < 8) begin
          all_done          = 1'b0;
          i_pe_out_valid[c] = 1'b1;
          i_pe_out_data[c]  = 32'((kc[c] * 16 + c + 1) << 4);
        end else begin
          i_pe_out_valid[c] = 1'b0;
        end
      end
      if (all_done) begin
        ok = 1'b1;
        break;
      end
      if (o_pe_out_ready != '1) saw_full = 1'b1;
      acc_m = i_pe_out_valid & o_pe_out_ready;
      tick();
      for (int c = 0; c < NCOL; c++) if (acc_m[c]) kc[c]++;
    end
    i_pe_out_valid = '0;
  endtask

  task automatic consume_bp(output int got);
    int stall;
    logic [BW-1:0] held;
    logic [NCOL-1:0][CW-1:0] e;
    got = 0;
    stall = 0;
    held = '0;
    for (int t = 0; t < 300 && got < 8; t++) begin
      if (o_actbuff_wr_valid) begin
        if (stall < 5) begin
          i_actbuff_wr_ready = 1'b0;
          if (stall > 0) chk("bp_held", o_data_out_to_actbuff, held);
          held = o_data_out_to_actbuff;
          stall++;
        end else begin
          i_actbuff_wr_ready = 1'b1;
          for (int c = 0; c < NCOL; c++) e[4'((c + 2) % NCOL)] = 17'(got * 16 + c + 1);
          chk($sformatf("bp_word%0d", got), o_data_out_to_actbuff, e);
          got++;
        end
      end else begin
        i_actbuff_wr_ready = 1'b0;
      end
      tick();
    end
    i_actbuff_wr_ready = 1'b1;
  endtask

  initial begin
    vec_t vecs[7];
    logic [NCOL-1:0][CW-1:0] e_dummy;
    logic [NCOL-1:0][CW-1:0] e_act;
    logic [NCOL-1:0][CW-1:0] e;
    logic [16:0] w;
    logic [16:0] relu_exp;
    bit seen;
    bit p_ok;
    bit p_full;
    int got;
    int d0;

    vecs[0] = '{32'h0000_0010, 32'h0000_0010, 5'd4,  1'b0, 2'd0, 17'h00001, 17'h00001};
    vecs[1] = '{32'h0001_0000, 32'h0000_0000, 5'd0,  1'b0, 2'd0, 17'h07FFF, 17'h00000};
    vecs[2] = '{32'hFFFF_0000, 32'h0000_0000, 5'd0,  1'b0, 2'd0, 17'h08000, 17'h00000};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 5'd0,  1'b0, 2'd0, 17'h10000, 17'h00000};
    vecs[4] = '{32'hFFFF_FFDF, 32'h0000_0000, 5'd2,  1'b0, 2'd0, 17'h0FFF7, 17'h00000};
    vecs[5] = '{32'h0000_0100, 32'h0000_0010, 5'd4,  1'b1, 2'd2, 17'h00010, 17'h00001};
    vecs[6] = '{32'h8000_0000, 32'h0000_0000, 5'd31, 1'b1, 2'd0, 17'h0FFFF, 17'h00000};

    rst_n = 1'b0;
    i_pe_out_valid = '0;
    i_pe_out_data = '0;
    i_start = 1'b0;
    i_cfg_num_words = '0;
    i_cfg_shift = '0;
    i_cfg_relu = 1'b0;
    i_out_sel = 1'b0;
    i_cfg_bank_offset = '0;
    i_dummy_ctrl_ready = 1'b1;
    i_actbuff_wr_ready = 1'b1;

    // Reset state, then a zero-word job
    tick(); tick(); tick();
    chk("rst_ready", o_pe_out_ready, '0);
    chk("rst_ctrl", {o_busy, o_done, o_dummy_ctrl_valid, o_actbuff_wr_valid}, '0);
    chk("rst_dummy_dat", o_data_out_to_dummy_ctrl, '0);
    chk("rst_act_dat", o_data_out_to_actbuff, '0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", o_pe_out_ready, {NCOL{1'b1}});
    start_job(16'd0, 5'd0, 1'b0, 1'b0, 2'd0);
    chk("nw0_s1_busy_done", {o_busy, o_done}, 2'b10);
    tick();
    chk("nw0_s2_done", {o_busy, o_done}, 2'b11);
    chk("nw0_no_valid", {o_dummy_ctrl_valid, o_actbuff_wr_valid}, 2'b00);
    tick();
    chk("nw0_idle", {o_busy, o_done}, 2'b00);

    // Single-word table vectors
    e_dummy = '0;
    e_act = '0;
    for (int i = 0; i < 7; i++) begin
      start_job(16'd1, vecs[i].shift, 1'b0, vecs[i].sel, vecs[i].off);
      for (int c = 0; c < NCOL; c++) i_pe_out_data[c] = 32'(vecs[i].acc0 + c * vecs[i].acc_step);
      i_pe_out_valid = '1;
      tick();
      i_pe_out_valid = '0;
      chk($sformatf("vec%0d_lat1_valid", i), {o_dummy_ctrl_valid, o_actbuff_wr_valid}, 2'b00);
      tick();
      for (int c = 0; c < NCOL; c++) begin
        w = 17'(vecs[i].exp0 + c * vecs[i].exp_step);
        if (vecs[i].sel) e_act[4'((c + vecs[i].off) % NCOL)] = w;
        else e_dummy[c] = w;
      end
      chk($sformatf("vec%0d_valid", i), {o_dummy_ctrl_valid, o_actbuff_wr_valid},
          vecs[i].sel ? 2'b01 : 2'b10);
      chk($sformatf("vec%0d_dummy_dat", i), o_data_out_to_dummy_ctrl, e_dummy);
      chk($sformatf("vec%0d_act_dat", i), o_data_out_to_actbuff, e_act);
      wait_done(10, seen);
      chk($sformatf("vec%0d_done", i), seen, 1'b1);
      tick();
    end

    // Bank path backpressure: 8 words, bank ready withheld 5 cycles
    i_actbuff_wr_ready = 1'b0;
    start_job(16'd8, 5'd4, 1'b0, 1'b1, 2'd2);
    fork
      produce_bp(p_ok, p_full);
      consume_bp(got);
    join
    chk("bp_producer_finished", p_ok, 1'b1);
    chk("bp_ready_dropped", p_full, 1'b1);
    chk("bp_words_received", got, 8);
    wait_done(10, seen);
    chk("bp_done", seen, 1'b1);
    tick();

    // Column 7 arrives 3 cycles late; words must stay row-aligned
    start_job(16'd2, 5'd0, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NCOL; c++) i_pe_out_data[c] = 32'(k * 100 + c + 1);
      i_pe_out_valid = 16'hFF7F;
      tick();
      chk($sformatf("c7_wait%0d", k), o_dummy_ctrl_valid, 1'b0);
    end
    i_pe_out_valid = '0;
    tick();
    chk("c7_wait2", o_dummy_ctrl_valid, 1'b0);
    for (int k = 0; k < 2; k++) begin
      i_pe_out_data[7] = 32'(k * 100 + 8);
      i_pe_out_valid = 16'h0080;
      tick();
      if (k == 0) chk("c7_wait3", o_dummy_ctrl_valid, 1'b0);
    end
    i_pe_out_valid = '0;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NCOL; c++) e[c] = 17'(k * 100 + c + 1);
      chk($sformatf("c7_word%0d_valid", k), o_dummy_ctrl_valid, 1'b1);
      chk($sformatf("c7_word%0d_dat", k), o_data_out_to_dummy_ctrl, e);
      tick();
    end
    wait_done(10, seen);
    chk("c7_done", seen, 1'b1);
    tick();

    // cfg_relu on a negative accumulator
`ifdef PE_DATA_OUT_RELU_EN
    relu_exp = 17'h10000;
`else
    relu_exp = 17'h0FFE0;
`endif
    start_job(16'd1, 5'd0, 1'b1, 1'b0, 2'd0);
    for (int c = 0; c < NCOL; c++) i_pe_out_data[c] = 32'hFFFF_FFE0;
    i_pe_out_valid = '1;
    tick();
    i_pe_out_valid = '0;
    tick();
    for (int c = 0; c < NCOL; c++) e[c] = relu_exp;
    chk("relu_dat", o_data_out_to_dummy_ctrl, e);
    wait_done(10, seen);
    chk("relu_done", seen, 1'b1);
    tick();

    // Reset in the middle of a stalled job
    i_dummy_ctrl_ready = 1'b0;
    start_job(16'd4, 5'd0, 1'b0, 1'b0, 2'd0);
    for (int c = 0; c < NCOL; c++) i_pe_out_data[c] = 32'd77;
    i_pe_out_valid = '1;
    tick();
    tick();
    i_pe_out_valid = '0;
    tick();
    chk("mid_valid_before_rst", o_dummy_ctrl_valid, 1'b1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {o_busy, o_done, o_dummy_ctrl_valid, o_actbuff_wr_valid}, '0);
    chk("mid_rst_ready", o_pe_out_ready, '0);
    tick();
    rst_n = 1'b1;
    i_dummy_ctrl_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("mid_no_done", done_cnt, d0);
    chk("mid_idle", o_busy, 1'b0);
    start_job(16'd1, 5'd0, 1'b0, 1'b0, 2'd0);
    for (int c = 0; c < NCOL; c++) i_pe_out_data[c] = 32'd5;
    i_pe_out_valid = '1;
    tick();
    i_pe_out_valid = '0;
    tick();
    for (int c = 0; c < NCOL; c++) e[c] = 17'h00005;
    chk("mid_flushed_dat", o_data_out_to_dummy_ctrl, e);
    wait_done(10, seen);
    chk("mid_after_done", seen, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
